// File: rtl/step_dir_monitor.sv
// STEP/DIR input monitor: synchronizes the driver lines, tracks signed position, measures
// step period and flags pulse-width, direction-setup/hold and position-overflow violations.
module step_dir_monitor #(
  parameter int unsigned MIN_HIGH  = 50,
  parameter int unsigned MIN_LOW   = 50,
  parameter int unsigned DIR_SETUP = 10,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned PERIOD_W  = 24
) (
  input  logic                clk_50,
  input  logic                reset_n,
  input  logic                step_in,
  input  logic                dir_in,
  input  logic                enable,
  input  logic                clear,
  output logic [POS_W-1:0]    position,
  output logic                step_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic                err_high,
  output logic                err_low,
  output logic                err_setup,
  output logic                pos_wrap
);

  localparam logic [15:0]         MinHigh   = 16'(MIN_HIGH);
  localparam logic [15:0]         MinLow    = 16'(MIN_LOW);
  localparam logic [7:0]          DirSetup  = 8'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] PeriodMax = '1;
  localparam logic [POS_W-1:0]    PosMax    = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0]    PosMin    = {1'b1, {(POS_W-1){1'b0}}};

  typedef enum logic [0:0] {StLow, StHigh} state_e;

  logic                step_meta_q, step_sync_q, step_prev_q;
  logic                dir_meta_q, dir_sync_q, dir_prev_q;
  logic [1:0]          fill_q;
  logic                armed_q;
  state_e              state_q;
  logic [15:0]         high_cnt_q, low_cnt_q;
  logic [7:0]          dir_cnt_q;
  logic [PERIOD_W-1:0] period_cnt_q;
  logic                have_prev_q;
  logic                rise, fall, dir_change, accept;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
      dir_meta_q  <= 1'b0;
      dir_sync_q  <= 1'b0;
      dir_prev_q  <= 1'b0;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      step_meta_q <= step_in;
      step_sync_q <= step_meta_q;
      step_prev_q <= step_sync_q;
      dir_meta_q  <= dir_in;
      dir_sync_q  <= dir_meta_q;
      dir_prev_q  <= dir_sync_q;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      // Only a low seen after the pipeline holds real samples arms edge detection.
      if (fill_q == 2'd3 && !step_sync_q) armed_q <= 1'b1;
    end
  end

  always_comb begin
    rise       = armed_q & step_sync_q & ~step_prev_q;
    fall       = (state_q == StHigh) & ~step_sync_q & step_prev_q;
    dir_change = (fill_q == 2'd3) & (dir_sync_q ^ dir_prev_q);
    accept     = rise & enable & ~clear;
    stalled    = (period_cnt_q == PeriodMax);
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StLow;
      high_cnt_q   <= '0;
      low_cnt_q    <= '1;
      dir_cnt_q    <= '1;
      period_cnt_q <= '0;
      have_prev_q  <= 1'b0;
      position     <= '0;
      step_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      err_high     <= 1'b0;
      err_low      <= 1'b0;
      err_setup    <= 1'b0;
      pos_wrap     <= 1'b0;
    end else begin
      unique case (state_q)
        StLow: begin
          if (rise) begin
            state_q    <= StHigh;
            high_cnt_q <= 16'd1;
          end else if (low_cnt_q != '1) begin
            low_cnt_q <= low_cnt_q + 16'd1;
          end
        end
        StHigh: begin
          if (fall) begin
            state_q   <= StLow;
            low_cnt_q <= 16'd1;
          end else if (high_cnt_q != '1) begin
            high_cnt_q <= high_cnt_q + 16'd1;
          end
        end
        default: state_q <= StLow;
      endcase

      if (dir_change)           dir_cnt_q <= 8'd0;
      else if (dir_cnt_q != '1) dir_cnt_q <= dir_cnt_q + 8'd1;

      if (rise)                            period_cnt_q <= 1;
      else if (period_cnt_q != PeriodMax)  period_cnt_q <= period_cnt_q + 1'b1;

      step_pulse <= accept;

      if (clear) begin
        position     <= '0;
        period       <= '0;
        period_valid <= 1'b0;
        have_prev_q  <= 1'b0;
        err_high     <= 1'b0;
        err_low      <= 1'b0;
        err_setup    <= 1'b0;
        pos_wrap     <= 1'b0;
      end else begin
        if (accept) begin
          if (dir_sync_q) begin
            position <= position + 1'b1;
            if (position == PosMax) pos_wrap <= 1'b1;
          end else begin
            position <= position - 1'b1;
            if (position == PosMin) pos_wrap <= 1'b1;
          end
          period       <= period_cnt_q;
          period_valid <= have_prev_q & (period_cnt_q != PeriodMax);
          have_prev_q  <= 1'b1;
        end
        if (enable) begin
          if (rise && low_cnt_q < MinLow)                err_low   <= 1'b1;
          if (rise && dir_cnt_q < DirSetup)              err_setup <= 1'b1;
          if (fall && high_cnt_q < MinHigh)              err_high  <= 1'b1;
          // DIR moving while STEP is high is a hold violation.
          if (dir_change && state_q == StHigh)           err_setup <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_dir_monitor.sv
// Scoreboard bench for step_dir_monitor: each driven STEP rise pushes the expected strobe
// (cycle, position, period); a negedge monitor pops and compares when step_pulse fires.
module tb_step_dir_monitor;

  localparam int unsigned PW   = 8;
  localparam int unsigned PERW = 12;
  localparam int unsigned PMAX = (1 << PERW) - 1;

  logic            clk_50 = 1'b0;
  logic            reset_n, step_in, dir_in, enable, clear;
  logic [PW-1:0]   position;
  logic            step_pulse;
  logic [PERW-1:0] period;
  logic            period_valid, stalled, err_high, err_low, err_setup, pos_wrap;

  step_dir_monitor #(
    .MIN_HIGH (50),
    .MIN_LOW  (50),
    .DIR_SETUP(10),
    .POS_W    (PW),
    .PERIOD_W (PERW)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .step_in     (step_in),
    .dir_in      (dir_in),
    .enable      (enable),
    .clear       (clear),
    .position    (position),
    .step_pulse  (step_pulse),
    .period      (period),
    .period_valid(period_valid),
    .stalled     (stalled),
    .err_high    (err_high),
    .err_low     (err_low),
    .err_setup   (err_setup),
    .pos_wrap    (pos_wrap)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    int unsigned     cyc;
    logic [PW-1:0]   pos;
    bit              chk_per;
    logic [PERW-1:0] per;
    bit              valid;
  } exp_t;

  exp_t          sb[$];
  int unsigned   cyc = 0;
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   n_pushed = 0;
  int unsigned   n_pulses = 0;
  logic [PW-1:0] model_pos = '0;
  bit            have_prev = 1'b0;
  bit            last_rise_ok = 1'b0;
  int unsigned   last_rise = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Called at #1 after a posedge; the DUT strobe is due three edges later.
  task automatic start_rise(input bit accept);
    exp_t        e;
    int unsigned diff;
    diff = cyc - last_rise;
    if (accept) begin
      if (dir_in) model_pos = model_pos + 1'b1;
      else        model_pos = model_pos - 1'b1;
      e.cyc     = cyc + 3;
      e.pos     = model_pos;
      e.chk_per = last_rise_ok;
      e.per     = (diff >= PMAX) ? PERW'(PMAX) : PERW'(diff);
      e.valid   = have_prev && (diff < PMAX);
      have_prev = 1'b1;
      sb.push_back(e);
      n_pushed++;
    end
    last_rise    = cyc;
    last_rise_ok = 1'b1;
    step_in      = 1'b1;
  endtask

  task automatic pulse(input int unsigned h, input int unsigned l);
    start_rise(enable);
    tick(h);
    step_in = 1'b0;
    tick(l);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear     = 1'b0;
    model_pos = '0;
    have_prev = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, err_high, err_low, err_setup, pos_wrap}, {28'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos"}, {24'd0, position}, 32'd0);
    check({tag, "_pulse"}, {31'd0, step_pulse}, 32'd0);
    check({tag, "_period"}, {20'd0, period}, 32'd0);
    check({tag, "_valid"}, {31'd0, period_valid}, 32'd0);
    check({tag, "_stalled"}, {31'd0, stalled}, 32'd0);
    check_flags({tag, "_flags"}, 4'b0000);
  endtask

  always @(negedge clk_50) begin : monitor
    exp_t e;
    if (reset_n && step_pulse) begin
      n_pulses++;
      if (sb.size() == 0) begin
        check("spurious_pulse", {31'd0, step_pulse}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_pos", {24'd0, position}, {24'd0, e.pos});
        if (e.chk_per) check("pulse_period", {20'd0, period}, {20'd0, e.per});
        check("pulse_valid", {31'd0, period_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    step_in = 1'b0;
    dir_in  = 1'b1;
    enable  = 1'b1;
    clear   = 1'b0;
    #3;
    check_all_zero("reset");
    tick(2);
    reset_n = 1'b1;
    tick(10);

    // Nominal forward stepping
    for (int i = 0; i < 5; i++) pulse(100, 400);
    check("nominal_pos", {24'd0, position}, 32'd5);
    check("nominal_period", {20'd0, period}, 32'd500);
    check("nominal_valid", {31'd0, period_valid}, 32'd1);
    check_flags("nominal_flags", 4'b0000);

    // Walk up to the positive limit, then overflow and come back
    while (model_pos != 8'h7f) pulse(60, 60);
    check("pre_wrap_pos", {24'd0, position}, 32'h7f);
    check_flags("pre_wrap_flags", 4'b0000);
    pulse(60, 60);
    check("wrap_up_pos", {24'd0, position}, 32'h80);
    check_flags("wrap_up_flags", 4'b0001);
    dir_in = 1'b0;
    tick(20);
    pulse(60, 60);
    check("wrap_down_pos", {24'd0, position}, 32'h7f);

    dir_in = 1'b1;
    tick(20);
    do_clear();
    check_all_zero("clear1");

    // Short high then short low
    pulse(20, 20);
    pulse(60, 60);
    check("width_pos", {24'd0, position}, 32'd2);
    check_flags("width_flags", 4'b1100);

    // DIR changed 5 cycles before STEP rise
    do_clear();
    dir_in = 1'b0;
    tick(5);
    pulse(60, 60);
    check("setup_pos", {24'd0, position}, 32'hff);
    check_flags("setup_flags", 4'b0010);

    // DIR changed while STEP is high
    do_clear();
    start_rise(enable);
    tick(30);
    dir_in = 1'b1;
    tick(30);
    step_in = 1'b0;
    tick(60);
    check_flags("hold_flags", 4'b0010);
    do_clear();
    check("clear2_pos", {24'd0, position}, 32'd0);
    check_flags("clear2_flags", 4'b0000);

    // Disabled: violating pulses are ignored
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse(20, 20);
    tick(60);
    enable = 1'b1;
    check("disabled_pos", {24'd0, position}, 32'd0);
    check_flags("disabled_flags", 4'b0000);
    pulse(60, 60);
    check("enabled_pos", {24'd0, position}, 32'd1);

    // Clear landing on the same cycle as an edge drops the edge
    start_rise(1'b0);
    tick(2);
    clear = 1'b1;
    tick(1);
    clear     = 1'b0;
    model_pos = '0;
    have_prev = 1'b0;
    tick(57);
    step_in = 1'b0;
    tick(60);
    check("clr_edge_pos", {24'd0, position}, 32'd0);
    check_flags("clr_edge_flags", 4'b0000);

    // Reset in the middle of a high pulse, released with STEP still high
    start_rise(enable);
    tick(20);
    check("pre_reset_pos", {24'd0, position}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_pos    = '0;
    have_prev    = 1'b0;
    last_rise_ok = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("post_reset_pos", {24'd0, position}, 32'd0);
    step_in = 1'b0;
    tick(60);
    pulse(60, 60);
    check("after_reset_pos", {24'd0, position}, 32'd1);

    // Long idle saturates the period counter
    tick(4200);
    check("stalled_set", {31'd0, stalled}, 32'd1);
    pulse(60, 60);
    check("stalled_clr", {31'd0, stalled}, 32'd0);
    check("stall_period", {20'd0, period}, PMAX);
    check("stall_valid", {31'd0, period_valid}, 32'd0);
    check("stall_pos", {24'd0, position}, 32'd2);

    tick(5);
    check("sb_empty", sb.size(), 32'd0);
    check("pulse_count", n_pulses, n_pushed);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
